xsim_msg_framer: RTL and testbench

Upstream feeder for the simulation message-source DPI stage. It accepts one portal message as a header (method id and payload length) followed by payload words, and buffers the whole message. It then emits the message as a contiguous burst of 32-bit beats: a framing header beat first, then the payload beats. The output drives the source stage's portal/en_beat/beat inputs directly, and that stage has no backpressure.

---
 rtl/xsim_msg_framer.sv | 164 ++++++++++++++++
 tb/tb_xsim_msg_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xsim_msg_framer.sv
// Message framer: buffers one header + payload message, then emits it as a gap-free
// burst of 32-bit beats (header beat first). Optional counters under XSIM_FRAMER_STATS_EN.
module xsim_msg_framer #(
    parameter int          MAX_WORDS = 16,
    parameter logic [31:0] PORTAL_ID = 32'd0,
    localparam int         NW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          s_hdr_valid,
    output logic          s_hdr_ready,
    input  logic [15:0]   s_hdr_method,
    input  logic [NW-1:0] s_hdr_nwords,
    input  logic          s_data_valid,
    output logic          s_data_ready,
    input  logic [31:0]   s_data,
    output logic [31:0]   portal,
    output logic          en_beat,
    output logic [31:0]   beat,
    output logic          err_len
`ifdef XSIM_FRAMER_STATS_EN
    ,
    output logic [31:0]   msg_count,
    output logic [31:0]   beat_count
`endif
);

    localparam int            AW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [NW-1:0] MAX_NW = NW'(MAX_WORDS);
    localparam logic [NW-1:0] ONE    = NW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SEND_HDR,
        S_SEND_BODY
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   method_q, method_d;
    logic [NW-1:0] nwords_q, nwords_d;
    logic          err_q, err_d;
    logic [31:0]   mem [MAX_WORDS];

    logic          hdr_fire;
    logic          data_fire;
    logic [15:0]   hdr_len;

    // Ready is forced low while RST is held so nothing is accepted during reset.
    assign s_hdr_ready  = (state_q == S_IDLE) && !RST;
    assign s_data_ready = (state_q == S_FILL) && !RST;
    assign hdr_fire     = s_hdr_valid && s_hdr_ready;
    assign data_fire    = s_data_valid && s_data_ready;
    assign portal       = PORTAL_ID;
    assign err_len      = err_q;
    assign hdr_len      = 16'(nwords_q) + 16'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            method_q <= '0;
            nwords_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            method_q <= method_d;
            nwords_q <= nwords_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (data_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        method_d = method_q;
        nwords_d = nwords_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hdr_fire) begin
                    method_d = s_hdr_method;
                    nwords_d = s_hdr_nwords;
                    wr_ptr_d = '0;
                    if (s_hdr_nwords > MAX_NW) begin
                        err_d = 1'b1;
                    end else if (s_hdr_nwords == '0) begin
                        state_d = S_SEND_HDR;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (data_fire) begin
                    if (wr_ptr_q == nwords_q - ONE) begin
                        state_d = S_SEND_HDR;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE;
                    end
                end
            end
            S_SEND_HDR: begin
                rd_ptr_d = '0;
                state_d  = (nwords_q == '0) ? S_IDLE : S_SEND_BODY;
            end
            S_SEND_BODY: begin
                if (rd_ptr_q == nwords_q - ONE) begin
                    rd_ptr_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    rd_ptr_d = rd_ptr_q + ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on flops; the source stage cannot stall, so no input feeds them.
    always_comb begin
        en_beat = 1'b0;
        beat    = '0;
        case (state_q)
            S_SEND_HDR: begin
                en_beat = 1'b1;
                beat    = {method_q, hdr_len};
            end
            S_SEND_BODY: begin
                en_beat = 1'b1;
                beat    = mem[rd_ptr_q[AW-1:0]];
            end
            default: ;
        endcase
    end

`ifdef XSIM_FRAMER_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            msg_count  <= '0;
            beat_count <= '0;
        end else begin
            if (state_q == S_SEND_HDR) begin
                msg_count <= msg_count + 32'd1;
            end
            if (en_beat) begin
                beat_count <= beat_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xsim_msg_framer.sv
// Directed + randomized bench for xsim_msg_framer: a queue model of expected beats
// and their cycle positions, checked with immediate assertions.
module tb_xsim_msg_framer;

    localparam int MAX_WORDS = 16;
    localparam int NW        = $clog2(MAX_WORDS + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          s_hdr_valid = 1'b0;
    logic          s_hdr_ready;
    logic [15:0]   s_hdr_method = '0;
    logic [NW-1:0] s_hdr_nwords = '0;
    logic          s_data_valid = 1'b0;
    logic          s_data_ready;
    logic [31:0]   s_data = '0;
    logic [31:0]   portal;
    logic          en_beat;
    logic [31:0]   beat;
    logic          err_len;
`ifdef XSIM_FRAMER_STATS_EN
    logic [31:0]   msg_count;
    logic [31:0]   beat_count;
`endif

    xsim_msg_framer #(.MAX_WORDS(MAX_WORDS), .PORTAL_ID(32'h0000_0000)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .s_hdr_valid  (s_hdr_valid),
        .s_hdr_ready  (s_hdr_ready),
        .s_hdr_method (s_hdr_method),
        .s_hdr_nwords (s_hdr_nwords),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready),
        .s_data       (s_data),
        .portal       (portal),
        .en_beat      (en_beat),
        .beat         (beat),
        .err_len      (err_len)
`ifdef XSIM_FRAMER_STATS_EN
        ,
        .msg_count    (msg_count),
        .beat_count   (beat_count)
`endif
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    int          err_cnt  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    time         obs_t[$];
    logic [31:0] words[$];
    time         acc_t;

    // monitor: record every beat with its sample time
    always @(negedge CLK) begin
        if (en_beat) begin
            obs_q.push_back(beat);
            obs_t.push_back($time);
        end
        if (err_len) err_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_hdr(input logic [15:0] m, input int n, input bit with_data);
        bit got = 0;
        int guard = 0;
        s_hdr_valid  = 1'b1;
        s_hdr_method = m;
        s_hdr_nwords = NW'(n);
        if (with_data) begin
            s_data_valid = 1'b1;
            s_data       = 32'hDEAD_BEEF;
        end
        while (!got && guard < 50) begin
            @(negedge CLK);
            got = s_hdr_ready;
            @(posedge CLK);
            acc_t = $time;
            #1;
            guard++;
        end
        s_hdr_valid  = 1'b0;
        s_data_valid = 1'b0;
        check("hdr_accept", 32'(got), 32'd1);
    endtask

    // valid pattern bits are used first (LSB first), then random bubbles
    task automatic drive_words(input int n, input int bubble_pct, input logic [15:0] pat, input int plen);
        int i = 0;
        int step = 0;
        while (i < n && step < 1000) begin
            s_data_valid = (step < plen) ? pat[step] : ($urandom_range(99) >= bubble_pct);
            s_data       = words[i];
            @(negedge CLK);
            if (s_data_valid && s_data_ready) begin
                i++;
                @(posedge CLK);
                acc_t = $time;
            end else begin
                @(posedge CLK);
            end
            #1;
            step++;
        end
        s_data_valid = 1'b0;
        check("data_accept_count", 32'(i), 32'(n));
    endtask

    task automatic compare_burst(input string tag);
        check({tag, "_beat_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
                check($sformatf("%s_time%0d", tag, i), 32'(obs_t[i] - acc_t), 32'(5 + 10 * i));
            end
        end
    endtask

    task automatic run_msg(input string tag, input logic [15:0] m, input int bubble_pct,
                           input logic [15:0] pat, input int plen, input bit with_data);
        int n = words.size();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
        exp_q.push_back({m, 16'(n + 1)});
        foreach (words[k]) exp_q.push_back(words[k]);
        send_hdr(m, n, with_data);
        if (n > 0) drive_words(n, bubble_pct, pat, plen);
        repeat (n + 4) @(posedge CLK);
        #1;
        compare_burst(tag);
    endtask

    initial begin
        // reset held with a header offered
        s_hdr_valid  = 1'b1;
        s_hdr_method = 16'h1234;
        s_hdr_nwords = NW'(2);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("rst_en_beat", 32'(en_beat), 32'd0);
            check("rst_hdr_ready", 32'(s_hdr_ready), 32'd0);
        end
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_beat", beat, 32'd0);
        @(posedge CLK);
        #1;
        s_hdr_valid = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        check("idle_hdr_ready", 32'(s_hdr_ready), 32'd1);
        check("idle_data_ready", 32'(s_data_ready), 32'd0);
        check("portal", portal, 32'h0);
        check("rst_no_beats", 32'(obs_q.size()), 32'd0);
        @(posedge CLK);
        #1;

        // three words, header offered together with a data word
        words = '{32'hA, 32'hB, 32'hC};
        run_msg("msg3", 16'h0005, 0, 16'h0, 0, 1'b1);
        check("msg3_hdr_value", exp_q[0], 32'h0005_0004);

        // empty message
        words.delete();
        run_msg("msg0", 16'h0007, 0, 16'h0, 0, 1'b0);

        // oversize header rejected
        obs_q.delete();
        obs_t.delete();
        err_cnt = 0;
        send_hdr(16'h0009, MAX_WORDS + 1, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        check("oversize_err_pulses", 32'(err_cnt), 32'd1);
        check("oversize_no_beats", 32'(obs_q.size()), 32'd0);
        @(negedge CLK);
        check("oversize_back_idle", 32'(s_hdr_ready), 32'd1);
        @(posedge CLK);
        #1;

        // full buffer
        words.delete();
        for (int k = 0; k < MAX_WORDS; k++) words.push_back($urandom);
        err_cnt = 0;
        run_msg("msgmax", 16'h00AB, 0, 16'h0, 0, 1'b0);
        check("msgmax_no_err", 32'(err_cnt), 32'd0);

        // bubble pattern 1,0,0,1,1,0,1
        words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        run_msg("bubbles", 16'h0C0D, 0, 16'b101_1001, 7, 1'b0);

        // randomized messages with random bubbles
        for (int m = 0; m < 6; m++) begin
            words.delete();
            for (int k = 0; k < $urandom_range(0, MAX_WORDS); k++) words.push_back($urandom);
            run_msg($sformatf("rand%0d", m), 16'($urandom), 30, 16'h0, 0, 1'b0);
        end

        // reset in the middle of a burst
        words.delete();
        for (int k = 0; k < 8; k++) words.push_back($urandom);
        send_hdr(16'h0E0E, 8, 1'b0);
        drive_words(8, 0, 16'h0, 0);
        begin
            int guard = 0;
            bit seen = 0;
            while (!seen && guard < 20) begin
                @(negedge CLK);
                seen = en_beat;
                guard++;
            end
            check("midsend_burst_started", 32'(seen), 32'd1);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("midsend_rst_en_beat", 32'(en_beat), 32'd0);
        check("midsend_rst_beat", beat, 32'd0);
        obs_q.delete();
        obs_t.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        check("midsend_no_residual", 32'(obs_q.size()), 32'd0);

        // reset after two of four words
        words = '{32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0BAD_0004};
        send_hdr(16'h0F0F, 4, 1'b0);
        drive_words(2, 0, 16'h0, 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        obs_q.delete();
        obs_t.delete();
        repeat (10) @(posedge CLK);
        #1;
        check("midfill_no_beats", 32'(obs_q.size()), 32'd0);

        words = '{32'h0000_0055};
        run_msg("after_rst", 16'h0006, 0, 16'h0, 0, 1'b0);
`ifdef XSIM_FRAMER_STATS_EN
        check("stats_msg_count", msg_count, 32'd1);
        check("stats_beat_count", beat_count, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
